// File: rtl/bus_arbiter_pkg.sv
// Shared arbiter constants: bus-owner state encoding and default burst sizing.
// Used by the arbiter, the DMA engine and the testbench.
package bus_arbiter_pkg;

    typedef enum logic {
        ST_CPU = 1'b0,
        ST_DMA = 1'b1
    } arb_st_e;

    localparam int DEF_MAX_BURST = 4;
    localparam int DEF_CW        = 8;

endpackage

// File: rtl/bus_arbiter_fsm.sv
// Bus-owner state machine: current owner, previous owner and DMA burst counter.
// BUS_ARB_SYNC_ALIGN_EN restricts DMA entry to opcode-fetch (cpu_sync) cycles.
module bus_arbiter_fsm
    import bus_arbiter_pkg::*;
#(
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int CW        = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dma_req,
    input  logic          cpu_sync,
    output logic          st,
    output logic          prev_dma,
    output logic [CW-1:0] cnt
);

    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

    arb_st_e       st_q, st_d;
    logic          prev_dma_q, prev_dma_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          grant_s;

`ifdef BUS_ARB_SYNC_ALIGN_EN
    assign grant_s = dma_req & cpu_sync;
`else
    logic unused_sync_s;
    assign unused_sync_s = cpu_sync;
    assign grant_s       = dma_req;
`endif

    // Next owner: the yield edge out of DMA wins over a still-pending request.
    always_comb begin
        st_d       = st_q;
        cnt_d      = cnt_q;
        prev_dma_d = (st_q == ST_DMA);
        case (st_q)
            ST_CPU: begin
                cnt_d = '0;
                if (grant_s) begin
                    st_d = ST_DMA;
                end else begin
                    st_d = ST_CPU;
                end
            end
            ST_DMA: begin
                if (!dma_req || (cnt_q == LAST_CNT)) begin
                    st_d  = ST_CPU;
                    cnt_d = '0;
                end else begin
                    st_d  = ST_DMA;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                st_d  = ST_CPU;
                cnt_d = '0;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q       <= ST_CPU;
            prev_dma_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            st_q       <= st_d;
            prev_dma_q <= prev_dma_d;
            cnt_q      <= cnt_d;
        end
    end

    assign st       = st_q;
    assign prev_dma = prev_dma_q;
    assign cnt      = cnt_q;

endmodule

// File: rtl/bus_arbiter.sv
// Shares one synchronous memory port between the 65C02 and a DMA requester,
// stalling the core via RDY and replaying its stolen read. Option: BUS_ARB_SYNC_ALIGN_EN.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int CW        = DEF_CW
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [15:0] cpu_ad,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_we,
    input  logic        cpu_sync,
    output logic [7:0]  cpu_di,
    output logic        cpu_rdy,
    input  logic        dma_req,
    input  logic [15:0] dma_ad,
    input  logic [7:0]  dma_do,
    input  logic        dma_we,
    output logic        dma_ack,
    output logic        dma_rvalid,
    output logic [7:0]  dma_di,
    output logic [15:0] mem_ad,
    output logic [7:0]  mem_do,
    output logic        mem_we,
    input  logic [7:0]  mem_di
);

    logic          st_s;
    logic          prev_dma_s;
    logic [CW-1:0] cnt_s;
    logic [7:0]    hold_q, hold_d;
    logic          dma_rvalid_q, dma_rvalid_d;

    bus_arbiter_fsm #(
        .MAX_BURST (MAX_BURST),
        .CW        (CW)
    ) u_fsm (
        .clk      (clk),
        .rst      (RST),
        .dma_req  (dma_req),
        .cpu_sync (cpu_sync),
        .st       (st_s),
        .prev_dma (prev_dma_s),
        .cnt      (cnt_s)
    );

    logic unused_cnt_s;
    assign unused_cnt_s = ^cnt_s;

    // Memory port mux and CPU stall; a dropped request in DMA state neither writes nor acks.
    always_comb begin
        if (st_s == ST_DMA) begin
            mem_ad  = dma_ad;
            mem_do  = dma_do;
            mem_we  = dma_we & dma_req;
            cpu_rdy = 1'b0;
            dma_ack = dma_req;
        end else begin
            mem_ad  = cpu_ad;
            mem_do  = cpu_do;
            mem_we  = cpu_we;
            cpu_rdy = 1'b1;
            dma_ack = 1'b0;
        end
    end

    // The first DMA cycle sees the data the CPU was about to read; keep it for replay.
    always_comb begin
        if ((st_s == ST_DMA) && !prev_dma_s) begin
            hold_d = mem_di;
        end else begin
            hold_d = hold_q;
        end
        if ((st_s == ST_CPU) && prev_dma_s) begin
            cpu_di = hold_q;
        end else begin
            cpu_di = mem_di;
        end
        dma_rvalid_d = dma_ack & ~dma_we;
    end

    // Replay and DMA read-valid registers.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            hold_q       <= 8'h00;
            dma_rvalid_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            dma_rvalid_q <= dma_rvalid_d;
        end
    end

    assign dma_rvalid = dma_rvalid_q;
    assign dma_di     = mem_di;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: vector table plus burst, reset and sync-alignment sequences.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] cpu_ad = 16'h0000;
    logic [7:0]  cpu_do = 8'h11;
    logic        cpu_we = 1'b0;
    logic        cpu_sync = 1'b0;
    logic [7:0]  cpu_di;
    logic        cpu_rdy;
    logic        dma_req = 1'b0;
    logic [15:0] dma_ad = 16'h0000;
    logic [7:0]  dma_do = 8'h00;
    logic        dma_we = 1'b0;
    logic        dma_ack;
    logic        dma_rvalid;
    logic [7:0]  dma_di;
    logic [15:0] mem_ad;
    logic [7:0]  mem_do;
    logic        mem_we;
    logic [7:0]  mem_di = 8'h00;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.MAX_BURST(4), .CW(8)) dut (
        .clk(clk), .RST(RST),
        .cpu_ad(cpu_ad), .cpu_do(cpu_do), .cpu_we(cpu_we), .cpu_sync(cpu_sync),
        .cpu_di(cpu_di), .cpu_rdy(cpu_rdy),
        .dma_req(dma_req), .dma_ad(dma_ad), .dma_do(dma_do), .dma_we(dma_we),
        .dma_ack(dma_ack), .dma_rvalid(dma_rvalid), .dma_di(dma_di),
        .mem_ad(mem_ad), .mem_do(mem_do), .mem_we(mem_we), .mem_di(mem_di)
    );

    typedef struct {
        logic [15:0] cad; logic cwe; logic csync; logic dreq;
        logic [15:0] dad; logic dwe; logic [7:0] ddo; logic [7:0] mdi;
        logic rdy; logic ack; logic [15:0] mad; logic mwe;
        logic [7:0] mdo; logic [7:0] cdi; logic rv;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [15:0] cad, input logic csync, input logic dreq,
                         input logic [15:0] dad, input logic dwe);
        cpu_ad = cad; cpu_we = 1'b0; cpu_sync = csync;
        dma_req = dreq; dma_ad = dad; dma_we = dwe; dma_do = 8'h00;
    endtask

    // Advance to the next cycle, leaving time for combinational outputs to settle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{16'h1234, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h00,
                    1'b1, 1'b0, 16'h1234, 1'b0, 8'h11, 8'h00, 1'b0};
        tbl[1]  = '{16'h1235, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h5A,
                    1'b1, 1'b0, 16'h1235, 1'b0, 8'h11, 8'h5A, 1'b0};
        tbl[2]  = '{16'h0200, 1'b0, 1'b1, 1'b1, 16'h8000, 1'b1, 8'h3C, 8'h6B,
                    1'b1, 1'b0, 16'h0200, 1'b0, 8'h11, 8'h6B, 1'b0};
        tbl[3]  = '{16'h0200, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b1, 8'h3C, 8'hA5,
                    1'b0, 1'b1, 16'h8000, 1'b1, 8'h3C, 8'hA5, 1'b0};
        tbl[4]  = '{16'h0200, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b1, 8'h3C, 8'hEE,
                    1'b0, 1'b0, 16'h8000, 1'b0, 8'h3C, 8'hEE, 1'b0};
        tbl[5]  = '{16'h0200, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h99,
                    1'b1, 1'b0, 16'h0200, 1'b0, 8'h11, 8'hA5, 1'b0};
        tbl[6]  = '{16'h0201, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 8'hA5,
                    1'b1, 1'b0, 16'h0201, 1'b0, 8'h11, 8'hA5, 1'b0};
        tbl[7]  = '{16'h0300, 1'b0, 1'b1, 1'b1, 16'h9000, 1'b0, 8'h00, 8'h42,
                    1'b1, 1'b0, 16'h0300, 1'b0, 8'h11, 8'h42, 1'b0};
        tbl[8]  = '{16'h0300, 1'b0, 1'b0, 1'b1, 16'h9000, 1'b0, 8'h00, 8'h31,
                    1'b0, 1'b1, 16'h9000, 1'b0, 8'h00, 8'h31, 1'b0};
        tbl[9]  = '{16'h0300, 1'b0, 1'b0, 1'b0, 16'h9000, 1'b0, 8'h00, 8'h77,
                    1'b0, 1'b0, 16'h9000, 1'b0, 8'h00, 8'h77, 1'b1};
        tbl[10] = '{16'h0300, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h55,
                    1'b1, 1'b0, 16'h0300, 1'b0, 8'h11, 8'h31, 1'b0};

        // Reset state
        cpu_we = 1'b1;
        #2;
        chk("rst_rdy", {15'd0, cpu_rdy}, 16'd1);
        chk("rst_ack", {15'd0, dma_ack}, 16'd0);
        chk("rst_rv", {15'd0, dma_rvalid}, 16'd0);
        chk("rst_we", {15'd0, mem_we}, 16'd1);
        cpu_we = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        RST = 1'b0;

        // Vector table: idle reads, DMA write with replay, DMA read with rvalid
        for (int i = 0; i < 11; i++) begin
            if (i != 0) next_cycle();
            cpu_ad = tbl[i].cad; cpu_we = tbl[i].cwe; cpu_sync = tbl[i].csync;
            dma_req = tbl[i].dreq; dma_ad = tbl[i].dad; dma_we = tbl[i].dwe;
            dma_do = tbl[i].ddo; mem_di = tbl[i].mdi;
            #3;
            chk($sformatf("v%0d_rdy", i), {15'd0, cpu_rdy}, {15'd0, tbl[i].rdy});
            chk($sformatf("v%0d_ack", i), {15'd0, dma_ack}, {15'd0, tbl[i].ack});
            chk($sformatf("v%0d_mad", i), mem_ad, tbl[i].mad);
            chk($sformatf("v%0d_mwe", i), {15'd0, mem_we}, {15'd0, tbl[i].mwe});
            chk($sformatf("v%0d_mdo", i), {8'd0, mem_do}, {8'd0, tbl[i].mdo});
            chk($sformatf("v%0d_cdi", i), {8'd0, cpu_di}, {8'd0, tbl[i].cdi});
            chk($sformatf("v%0d_rv", i), {15'd0, dma_rvalid}, {15'd0, tbl[i].rv});
            chk($sformatf("v%0d_ddi", i), {8'd0, dma_di}, {8'd0, tbl[i].mdi});
        end

        // Held request: 4 DMA cycles then one forced CPU cycle, repeated
        for (int k = 0; k < 12; k++) begin
            next_cycle();
            drive(16'h0400, 1'b1, 1'b1, 16'hA000 + 16'(k), 1'b1);
            #3;
            chk($sformatf("burst%0d_rdy", k), {15'd0, cpu_rdy}, {15'd0, (k % 5) == 0});
            chk($sformatf("burst%0d_ack", k), {15'd0, dma_ack}, {15'd0, (k % 5) != 0});
            chk($sformatf("burst%0d_mwe", k), {15'd0, mem_we}, {15'd0, (k % 5) != 0});
        end
        next_cycle();
        drive(16'h0400, 1'b1, 1'b0, 16'hA00C, 1'b1);
        #3;
        chk("drop_ack", {15'd0, dma_ack}, 16'd0);
        chk("drop_mwe", {15'd0, mem_we}, 16'd0);
        chk("drop_rdy", {15'd0, cpu_rdy}, 16'd0);
        next_cycle();
        #3;
        chk("drop_back_rdy", {15'd0, cpu_rdy}, 16'd1);

        // Reset during the 2nd cycle of a DMA read burst
        next_cycle();
        drive(16'h0600, 1'b1, 1'b1, 16'hB000, 1'b0);
        next_cycle();
        #3;
        chk("rb_first_ack", {15'd0, dma_ack}, 16'd1);
        next_cycle();
        #1;
        chk("rb_second_rv", {15'd0, dma_rvalid}, 16'd1);
        RST = 1'b1;
        #1;
        chk("rb_rdy", {15'd0, cpu_rdy}, 16'd1);
        chk("rb_ack", {15'd0, dma_ack}, 16'd0);
        chk("rb_rv", {15'd0, dma_rvalid}, 16'd0);
        next_cycle();
        RST = 1'b0;
        #3;
        chk("rb_rel_rdy", {15'd0, cpu_rdy}, 16'd1);
        chk("rb_rel_mad", mem_ad, 16'h0600);
        chk("rb_rel_rv", {15'd0, dma_rvalid}, 16'd0);
        next_cycle();
        #3;
        chk("rb_regrant_ack", {15'd0, dma_ack}, 16'd1);
        next_cycle();
        drive(16'h0600, 1'b1, 1'b0, 16'hB000, 1'b0);
        next_cycle();
        #3;
        chk("rb_end_rdy", {15'd0, cpu_rdy}, 16'd1);

        // Request raised mid-instruction (cpu_sync low)
        next_cycle();
        drive(16'h0500, 1'b0, 1'b1, 16'hC000, 1'b1);
        #3;
        chk("sync0_rdy", {15'd0, cpu_rdy}, 16'd1);
        next_cycle();
`ifdef BUS_ARB_SYNC_ALIGN_EN
        #3;
        chk("sync1_defer_rdy", {15'd0, cpu_rdy}, 16'd1);
        chk("sync1_defer_ack", {15'd0, dma_ack}, 16'd0);
        next_cycle();
        cpu_sync = 1'b1;
        #3;
        chk("sync2_defer_rdy", {15'd0, cpu_rdy}, 16'd1);
        next_cycle();
        cpu_sync = 1'b0;
        #3;
        chk("sync3_grant_ack", {15'd0, dma_ack}, 16'd1);
        chk("sync3_grant_rdy", {15'd0, cpu_rdy}, 16'd0);
`else
        #3;
        chk("sync1_grant_ack", {15'd0, dma_ack}, 16'd1);
        chk("sync1_grant_rdy", {15'd0, cpu_rdy}, 16'd0);
        chk("sync1_grant_mad", mem_ad, 16'hC000);
`endif
        next_cycle();
        dma_req = 1'b0;
        next_cycle();
        #3;
        chk("final_rdy", {15'd0, cpu_rdy}, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
